// File: rtl/single_port_mem_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | single_port_mem_arbiter_pkg                                              |
// | Shared FSM encoding, client indices and the CLOG2 helper macro.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package single_port_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spm_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | spm_rr_arbiter                                                           |
// | Two-client grant logic; round-robin when SPM_ROUND_ROBIN_EN is defined,  |
// | otherwise fixed priority with client A first.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module spm_rr_arbiter
  import single_port_mem_arbiter_pkg::*;
(
`ifdef SPM_ROUND_ROBIN_EN
  input  logic       clock,
  input  logic       rst_n,
`endif
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic [1:0] w_req;
  logic       w_a_wins;

  assign w_req = req_i & {2{en_i}};

`ifdef SPM_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // Only an actual grant moves the pointer, so an idle cycle never flips priority.
  assign w_a_wins = !w_req[CLI_B] || (last_q == CLI_B);

  always_comb begin
    last_d = last_q;
    if (gnt_o[CLI_B]) begin
      last_d = CLI_B;
    end else if (gnt_o[CLI_A]) begin
      last_d = CLI_A;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CLI_B;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign w_a_wins = 1'b1;
`endif

  always_comb begin
    gnt_o        = '0;
    gnt_o[CLI_A] = w_req[CLI_A] && w_a_wins;
    gnt_o[CLI_B] = w_req[CLI_B] && !gnt_o[CLI_A];
  end

endmodule

`default_nettype wire

// File: rtl/single_port_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | single_port_mem_arbiter                                                  |
// | Serialises two clients onto a single-port memory, routes read data back  |
// | and optionally zero-fills the memory after reset. Arbitration policy is  |
// | selected by the SPM_ROUND_ROBIN_EN macro.                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module single_port_mem_arbiter
  import single_port_mem_arbiter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 64,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = `CLOG2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,

  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic             a_req_wr,
  input  logic [AW-1:0]    a_req_addr,
  input  logic [WIDTH-1:0] a_req_data,
  output logic             a_rsp_valid,
  output logic [WIDTH-1:0] a_rsp_data,

  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic             b_req_wr,
  input  logic [AW-1:0]    b_req_addr,
  input  logic [WIDTH-1:0] b_req_data,
  output logic             b_rsp_valid,
  output logic [WIDTH-1:0] b_rsp_data,

  output logic [WIDTH-1:0] mem_data,
  output logic [AW-1:0]    mem_address,
  output logic             mem_wr_en,
  input  logic [WIDTH-1:0] mem_q,

  output logic             init_done
);

  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
  localparam state_t        c_st_reset  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic          clr_wr_q;
  logic          init_done_q;
  logic          a_rsp_valid_q;
  logic          b_rsp_valid_q;
  logic [1:0]    w_gnt;

  spm_rr_arbiter u_arb (
`ifdef SPM_ROUND_ROBIN_EN
    .clock (clock),
    .rst_n (rst_n),
`endif
    .en_i  (init_done_q),
    .req_i ({b_req_valid, a_req_valid}),
    .gnt_o (w_gnt)
  );

  assign a_req_ready = w_gnt[CLI_A];
  assign b_req_ready = w_gnt[CLI_B];
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = mem_q;
  assign b_rsp_data  = mem_q;
  assign init_done   = init_done_q;

  // Sweep writes and client grants never overlap: init_done only rises as clr_wr_q falls.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_address = addr_q;
    mem_data    = '0;
    if (clr_wr_q) begin
      mem_wr_en   = 1'b1;
      mem_address = ptr_q;
    end else if (w_gnt[CLI_A]) begin
      mem_wr_en   = a_req_wr;
      mem_address = a_req_addr;
      mem_data    = a_req_data;
    end else if (w_gnt[CLI_B]) begin
      mem_wr_en   = b_req_wr;
      mem_address = b_req_addr;
      mem_data    = b_req_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_st_reset;
      ptr_q         <= '0;
      addr_q        <= '0;
      clr_wr_q      <= 1'b0;
      init_done_q   <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      addr_q        <= mem_address;
      a_rsp_valid_q <= w_gnt[CLI_A] && !a_req_wr;
      b_rsp_valid_q <= w_gnt[CLI_B] && !b_req_wr;
      case (state_q)
        ST_CLEAR: begin
          if (!clr_wr_q) begin
            clr_wr_q <= 1'b1;
          end else if (ptr_q == c_last_addr) begin
            clr_wr_q    <= 1'b0;
            ptr_q       <= '0;
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_single_port_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_single_port_mem_arbiter                                               |
// | Self-checking bench: clear sweep, directed vector table, randomized      |
// | traffic against a reference model, mid-operation reset, DEPTH=48 sweep.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_single_port_mem_arbiter;

  localparam int W  = 8;
  localparam int D  = 64;
  localparam int AW = 6;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic          a_req_valid, a_req_ready, a_req_wr, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [W-1:0]  a_req_data, a_rsp_data;
  logic          b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [W-1:0]  b_req_data, b_rsp_data;
  logic [W-1:0]  mem_data, mem_q;
  logic [AW-1:0] mem_address;
  logic          mem_wr_en, init_done;

  single_port_mem_arbiter #(.WIDTH(W), .DEPTH(D), .CLEAR_ON_RESET(1)) dut (
    .clock(clock), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_data(a_req_data),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_data(b_req_data),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_data(mem_data), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_q(mem_q), .init_done(init_done)
  );

  // Second instance with a non-power-of-two depth and idle clients.
  logic          x48_a_ready, x48_b_ready, x48_a_rsp_valid, x48_b_rsp_valid;
  logic [W-1:0]  x48_a_rsp_data, x48_b_rsp_data, m48_data;
  logic [AW-1:0] m48_addr;
  logic          m48_wr, done48;

  single_port_mem_arbiter #(.WIDTH(W), .DEPTH(48), .CLEAR_ON_RESET(1)) dut48 (
    .clock(clock), .rst_n(rst_n),
    .a_req_valid(1'b0), .a_req_ready(x48_a_ready), .a_req_wr(1'b0),
    .a_req_addr(6'd0), .a_req_data(8'd0),
    .a_rsp_valid(x48_a_rsp_valid), .a_rsp_data(x48_a_rsp_data),
    .b_req_valid(1'b0), .b_req_ready(x48_b_ready), .b_req_wr(1'b0),
    .b_req_addr(6'd0), .b_req_data(8'd0),
    .b_rsp_valid(x48_b_rsp_valid), .b_rsp_data(x48_b_rsp_data),
    .mem_data(m48_data), .mem_address(m48_addr), .mem_wr_en(m48_wr),
    .mem_q(8'd0), .init_done(done48)
  );

  // Memory behind the main instance: registered q, read-old-data on write.
  logic [W-1:0] mem [0:D-1];
  initial begin
    for (int i = 0; i < D; i++) mem[i] <= 8'($urandom);
  end
  always @(posedge clock) begin
    if (mem_wr_en) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  int cnt48 = 0, bad48 = 0, max48 = 0;
  always @(negedge clock) begin
    if (rst_n && m48_wr) begin
      cnt48 <= cnt48 + 1;
      if (int'(m48_addr) >= 48 || m48_data != 8'd0) bad48 <= bad48 + 1;
      if (int'(m48_addr) > max48) max48 <= int'(m48_addr);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input string tag);
    int  n_wr = 0;
    int  bad  = 0;
    bit  done = 0;
    bit  prev63 = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge clock); #4;
      if (init_done) begin
        done = 1;
      end else begin
        if (a_req_ready || b_req_ready) bad++;
        if (mem_wr_en) begin
          if (mem_address !== 6'(n_wr) || mem_data !== 8'd0) bad++;
          n_wr++;
        end else if (n_wr != 0) begin
          bad++;
        end
        prev63 = mem_wr_en && (mem_address == 6'd63);
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " writes"}, 32'(n_wr), 32'd64);
    chk({tag, " bad cycles"}, 32'(bad), 32'd0);
    chk({tag, " done after addr 63"}, 32'(prev63), 32'd1);
  endtask

  typedef struct {
    logic       av, awr;
    logic [5:0] aaddr;
    logic [7:0] adata;
    logic       bv, bwr;
    logic [5:0] baddr;
    logic [7:0] bdata;
    logic       e_ra, e_rb, e_wr;
    logic [5:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_rspa, e_rspb;
    logic [7:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input int av, awr, aa, ad, bv, bwr, ba, bd,
                              era, erb, ewr, ea, ed, rspa, rspb, rd);
    vec_t v;
    v.av = av[0];  v.awr = awr[0];  v.aaddr = 6'(aa);  v.adata = 8'(ad);
    v.bv = bv[0];  v.bwr = bwr[0];  v.baddr = 6'(ba);  v.bdata = 8'(bd);
    v.e_ra = era[0];  v.e_rb = erb[0];  v.e_wr = ewr[0];
    v.e_addr = 6'(ea);  v.e_wdata = 8'(ed);
    v.e_rspa = rspa[0];  v.e_rspb = rspb[0];  v.e_rdata = 8'(rd);
    return v;
  endfunction

  vec_t       tbl [12];
  logic [7:0] model_mem [0:D-1];
  logic [5:0] m_last_addr;
  bit         m_lastB;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    bit pa, pb, pref_a, ga, gb, e_wr, e_rspa, e_rspb;
    logic [5:0] e_addr;
    logic [7:0] e_data, e_rdata;

    // A presents a read of addr 17 throughout reset and the sweep; it must be held.
    a_req_valid = 1; a_req_wr = 0; a_req_addr = 6'd17; a_req_data = 0;
    b_req_valid = 0; b_req_wr = 0; b_req_addr = 0;     b_req_data = 0;

    repeat (3) @(posedge clock);
    #4;
    chk("reset init_done", 32'(init_done), 0);
    chk("reset mem_wr_en", 32'(mem_wr_en), 0);
    chk("reset a_req_ready", 32'(a_req_ready), 0);
    chk("reset rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 0);
    chk("reset init_done48", 32'(done48), 0);

    @(posedge clock); #1;
    rst_n = 1;
    run_sweep("sweep");
    chk("post-sweep a_req_ready", 32'(a_req_ready), 1);
    @(posedge clock); #1;
    a_req_valid = 0;
    #1;
    chk("read17 a_rsp_valid", 32'(a_rsp_valid), 1);
    chk("read17 a_rsp_data", 32'(a_rsp_data), 0);
    chk("read17 b_rsp_valid", 32'(b_rsp_valid), 0);
    @(posedge clock); #4;
    chk("read17 rsp one cycle", 32'(a_rsp_valid), 0);

    for (int i = 0; i < D; i++) model_mem[i] = 8'd0;
    m_last_addr = 6'd17;
    m_lastB     = 0;

    tbl[0]  = mk(1,1,5,'hA5, 0,0,0,0,     1,0,1,5,'hA5, 0,0,0);
    tbl[1]  = mk(1,0,5,0,    0,0,0,0,     1,0,0,5,0,    1,0,'hA5);
    tbl[2]  = mk(0,0,0,0,    0,0,0,0,     0,0,0,5,0,    0,0,0);
    tbl[3]  = mk(0,0,0,0,    1,1,9,'h22,  0,1,1,9,'h22, 0,0,0);
    tbl[4]  = mk(1,1,9,'h11, 1,0,9,0,     1,0,1,9,'h11, 0,0,0);
    tbl[5]  = mk(0,0,0,0,    1,0,9,0,     0,1,0,9,0,    0,1,'h11);
    tbl[6]  = mk(1,1,3,'h33, 0,0,0,0,     1,0,1,3,'h33, 0,0,0);
    tbl[7]  = mk(0,0,0,0,    1,1,4,'h44,  0,1,1,4,'h44, 0,0,0);
    tbl[8]  = mk(1,0,3,0,    1,0,4,0,     1,0,0,3,0,    1,0,'h33);
    tbl[10] = mk(1,0,3,0,    1,0,4,0,     1,0,0,3,0,    1,0,'h33);
`ifdef SPM_ROUND_ROBIN_EN
    tbl[9]  = mk(1,0,3,0,    1,0,4,0,     0,1,0,4,0,    0,1,'h44);
    tbl[11] = mk(1,0,3,0,    1,0,4,0,     0,1,0,4,0,    0,1,'h44);
`else
    tbl[9]  = mk(1,0,3,0,    1,0,4,0,     1,0,0,3,0,    1,0,'h33);
    tbl[11] = mk(1,0,3,0,    1,0,4,0,     1,0,0,3,0,    1,0,'h33);
`endif

    for (int i = 0; i < 12; i++) begin
      a_req_valid = tbl[i].av; a_req_wr = tbl[i].awr; a_req_addr = tbl[i].aaddr; a_req_data = tbl[i].adata;
      b_req_valid = tbl[i].bv; b_req_wr = tbl[i].bwr; b_req_addr = tbl[i].baddr; b_req_data = tbl[i].bdata;
      #2;
      chk($sformatf("t%0d a_req_ready", i), 32'(a_req_ready), 32'(tbl[i].e_ra));
      chk($sformatf("t%0d b_req_ready", i), 32'(b_req_ready), 32'(tbl[i].e_rb));
      chk($sformatf("t%0d mem_wr_en", i), 32'(mem_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("t%0d mem_address", i), 32'(mem_address), 32'(tbl[i].e_addr));
      if (tbl[i].e_wr) chk($sformatf("t%0d mem_data", i), 32'(mem_data), 32'(tbl[i].e_wdata));
      if (tbl[i].e_wr) model_mem[tbl[i].e_addr] = tbl[i].e_wdata;
      if (tbl[i].e_ra) m_lastB = 0;
      if (tbl[i].e_rb) m_lastB = 1;
      m_last_addr = tbl[i].e_addr;
      @(posedge clock); #4;
      chk($sformatf("t%0d a_rsp_valid", i), 32'(a_rsp_valid), 32'(tbl[i].e_rspa));
      chk($sformatf("t%0d b_rsp_valid", i), 32'(b_rsp_valid), 32'(tbl[i].e_rspb));
      if (tbl[i].e_rspa) chk($sformatf("t%0d a_rsp_data", i), 32'(a_rsp_data), 32'(tbl[i].e_rdata));
      if (tbl[i].e_rspb) chk($sformatf("t%0d b_rsp_data", i), 32'(b_rsp_data), 32'(tbl[i].e_rdata));
    end

    // Randomized traffic; a refused request is held unchanged by its client.
    pa = 0; pb = 0;
    for (int c = 0; c < 300; c++) begin
      if (!pa) begin
        a_req_valid = ($urandom_range(0, 3) != 0); a_req_wr = 1'($urandom_range(0, 1));
        a_req_addr = 6'($urandom); a_req_data = 8'($urandom);
      end
      if (!pb) begin
        b_req_valid = ($urandom_range(0, 3) != 0); b_req_wr = 1'($urandom_range(0, 1));
        b_req_addr = 6'($urandom); b_req_data = 8'($urandom);
      end
`ifdef SPM_ROUND_ROBIN_EN
      pref_a = m_lastB;
`else
      pref_a = 1;
`endif
      ga = a_req_valid && (!b_req_valid || pref_a);
      gb = b_req_valid && !ga;
      e_wr    = ga ? a_req_wr   : gb ? b_req_wr   : 1'b0;
      e_addr  = ga ? a_req_addr : gb ? b_req_addr : m_last_addr;
      e_data  = ga ? a_req_data : b_req_data;
      e_rspa  = ga && !a_req_wr;
      e_rspb  = gb && !b_req_wr;
      e_rdata = model_mem[e_addr];
      #2;
      chk($sformatf("r%0d a_req_ready", c), 32'(a_req_ready), 32'(ga));
      chk($sformatf("r%0d b_req_ready", c), 32'(b_req_ready), 32'(gb));
      chk($sformatf("r%0d mem_wr_en", c), 32'(mem_wr_en), 32'(e_wr));
      chk($sformatf("r%0d mem_address", c), 32'(mem_address), 32'(e_addr));
      if (e_wr) chk($sformatf("r%0d mem_data", c), 32'(mem_data), 32'(e_data));
      if (e_wr) model_mem[e_addr] = e_data;
      if (ga) m_lastB = 0;
      if (gb) m_lastB = 1;
      m_last_addr = e_addr;
      pa = a_req_valid && !ga;
      pb = b_req_valid && !gb;
      @(posedge clock); #4;
      chk($sformatf("r%0d a_rsp_valid", c), 32'(a_rsp_valid), 32'(e_rspa));
      chk($sformatf("r%0d b_rsp_valid", c), 32'(b_rsp_valid), 32'(e_rspb));
      if (e_rspa || e_rspb) chk($sformatf("r%0d rsp_data", c),
                                32'(e_rspa ? a_rsp_data : b_rsp_data), 32'(e_rdata));
    end

    // Reset lands in the cycle a read response is being presented.
    a_req_valid = 1; a_req_wr = 0; a_req_addr = 6'd5; b_req_valid = 0;
    #2;
    chk("mid a_req_ready", 32'(a_req_ready), 1);
    @(posedge clock); #1;
    a_req_valid = 0;
    chk("mid rsp_valid before reset", 32'(a_rsp_valid), 1);
    #1 rst_n = 0;
    #1;
    chk("mid rsp_valid killed", 32'(a_rsp_valid), 0);
    chk("mid init_done dropped", 32'(init_done), 0);
    chk("mid mem_wr_en", 32'(mem_wr_en), 0);
    @(posedge clock); #1;
    rst_n = 1;
    run_sweep("resweep");

    chk("d48 init_done", 32'(done48), 1);
    chk("d48 sweep writes", 32'(cnt48), 32'd96);
    chk("d48 bad writes", 32'(bad48), 0);
    chk("d48 highest addr", 32'(max48), 32'd47);
    chk("d48 idle outputs", {28'd0, x48_a_ready, x48_b_ready, x48_a_rsp_valid, x48_b_rsp_valid}, 0);
    chk("d48 rsp data", {16'd0, x48_a_rsp_data, x48_b_rsp_data}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/single_port_mem_arbiter.md
Name: single_port_mem_arbiter

Overview:
- Front-end controller placed directly upstream of the single-ported M20K memory wrapper.
- Serialises read/write requests from two clients (A, B) onto the memory's one-access-per-cycle port.
- Routes registered read data back to the client that issued the read.
- Optionally zero-fills the memory after reset, because the memory wrapper performs no initialisation.

Parameters:
- WIDTH, 8, data word width; must match the memory.
- DEPTH, 64, number of words; address width AW = `CLOG2(DEPTH).
- CLEAR_ON_RESET, 1, when 1 sweep-write zeros to all DEPTH words after reset before serving clients.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req_valid  in  1  client A request valid.
- a_req_ready  out  1  client A request accepted this cycle.
- a_req_wr  in  1  1 = write, 0 = read.
- a_req_addr  in  AW  request address.
- a_req_data  in  WIDTH  write data.
- a_rsp_valid  out  1  client A read data valid.
- a_rsp_data  out  WIDTH  client A read data.
- b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_data, b_rsp_valid, b_rsp_data: same as A, for client B.
- mem_data  out  WIDTH  to memory data.
- mem_address  out  AW  to memory address.
- mem_wr_en  out  1  to memory wr_en.
- mem_q  in  WIDTH  from memory q; registered, valid one cycle after the address is sampled.
- init_done  out  1  high once the clear sweep is finished (or immediately if CLEAR_ON_RESET = 0).

Behaviour:
- Interface: single clock "clock"; reset "rst_n" is asynchronous and active-low.
- Reset values: init_done = 0, a/b_rsp_valid = 0, a/b_req_ready = 0, mem_wr_en = 0, clear pointer = 0, round-robin last-grant = B (so A wins first).
- FSM states:
  - CLEAR: entered from reset when CLEAR_ON_RESET = 1. mem_wr_en = 1, mem_data = 0, mem_address = pointer; pointer increments each cycle. When pointer == DEPTH-1 (not 2^AW-1), move to RUN. Both req_ready outputs are 0 in CLEAR.
  - RUN: init_done = 1. Reached directly from reset when CLEAR_ON_RESET = 0.
- Arbitration (RUN, combinational): at most one grant per cycle. Only one valid → that client is granted. Both valid → priority rule (see Optional Feature).
- Grant outputs: x_req_ready = grant_x; a transfer occurs when valid && ready. No valid → mem_wr_en = 0 and address holds its last value.
- Memory drive: mem_address/mem_data/mem_wr_en are driven combinationally from the granted client, so the memory samples them on the same edge as the handshake.
- Read response:
  - Read accepted at edge N → x_rsp_valid registered high for exactly the cycle after edge N.
  - x_rsp_data = mem_q passed through, with no extra register. Latency is 1 cycle.
  - No response backpressure; the client must consume the data.
  - The non-issuing client's rsp_valid stays 0; rsp_data is don't-care when rsp_valid is low.
- Writes produce no response. The memory's q after a write (old data) is ignored.
- Back-to-back: one grant per cycle. Full throughput is 1 access/cycle across both clients.
- Reset mid-operation: asynchronously kills a pending rsp_valid, restarts CLEAR from address 0, and drops init_done.
- Requests presented before init_done are held by the clients; they are not accepted or lost.

Optional Feature:
- Macro SPM_ROUND_ROBIN_EN.
- Defined: on contention, the client not granted last time wins. Last-grant updates only on an accepted transfer.
- Undefined: fixed priority, A always beats B; no last-grant register.

Decomposition:
- Shared package holds the FSM state encoding (ST_CLEAR, ST_RUN), the client index constants (CLI_A = 0, CLI_B = 1), and the `CLOG2 macro include.
- One sub-module is natural: spm_rr_arbiter, a 2-input arbiter with the last-grant register and the SPM_ROUND_ROBIN_EN switch.
- Datapath muxing and the FSM stay in the top module.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, DEPTH = 64 → mem_wr_en high for exactly 64 cycles, addresses 0..63, data 0. init_done rises the cycle after address 63. A read of address 17 then returns 0.
- A writes 8'hA5 to addr 5, then A reads addr 5 → a_rsp_valid high exactly one cycle after acceptance with a_rsp_data = 8'hA5; b_rsp_valid stays 0.
- A and B both request reads (addrs 3, 4) continuously for 4 cycles with SPM_ROUND_ROBIN_EN defined → grants alternate A,B,A,B. Undefined → A granted all 4 cycles, B starved.
- Same-cycle contention: A writes 8'h11 to addr 9 while B reads addr 9, A granted first → B's read (next cycle) returns 8'h11.
- Assert rst_n low in the cycle after a read is accepted → rsp_valid goes 0 immediately, init_done drops, and CLEAR restarts at address 0.
- DEPTH = 48 (non-power-of-2) → CLEAR sweep stops at address 47; no write to addresses 48..63 ever issued.
